// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: sizing defaults,
// address-split widths, the entry record and a tag extraction helper.
package btb_pkg;

  localparam int BTB_ENTRIES_DEF = 16;
  localparam int BTB_IDX_W_DEF   = $clog2(BTB_ENTRIES_DEF);
  localparam int BTB_TAG_W_DEF   = 32 - BTB_IDX_W_DEF - 2;
  // Stored tag width covers the smallest legal table (4 entries, 28-bit tag);
  // larger tables keep the unused upper tag bits at zero.
  localparam int BTB_TAG_W_MAX   = 28;

  typedef logic [BTB_TAG_W_MAX-1:0] btb_tag_t;

  typedef struct packed {
    logic        valid;
    btb_tag_t    tag;
    logic [31:0] target;
  } btb_entry_t;

  // Tag = PC[31:idx_w+2], zero-extended to the stored width.
  function automatic btb_tag_t btb_tag(input logic [31:0] pc, input int idx_w);
    logic [31:0] s;
    s = pc >> (idx_w + 2);
    return s[BTB_TAG_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/btb_tag_array.sv
// Entry storage for the branch target buffer: one combinational read port,
// one synchronous write port and one tag-qualified invalidate port.
// Only the valid bits are reset; tag/target contents are don't-care while invalid.
module btb_tag_array
  import btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES_DEF,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_target,
  input  btb_tag_t         wr_tag,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx,
  input  btb_tag_t         inv_tag
);

  logic [ENTRIES-1:0] valid_q;
  btb_tag_t           tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  // Read port sees pre-edge contents, so a same-cycle write is not bypassed.
  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid_q[rd_idx];
    rd_entry.tag    = tag_q[rd_idx];
    rd_entry.target = tgt_q[rd_idx];
  end

  // Valid bits: reset wins over any pending write; invalidate needs a tag match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end else if (inv_en && (tag_q[inv_idx] == inv_tag)) begin
      valid_q[inv_idx] <= 1'b0;
    end
  end

  // Payload write; suppressed during reset so a reset-cycle write leaves no trace.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      tgt_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer in IF. Combinational lookup of PC_IF,
// trained from ID one cycle later. Optional counters under BTB_STATS_EN.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter  int ENTRIES = BTB_ENTRIES_DEF,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] PC_IF,
  output logic        branch_IF,
  output logic [31:0] PC_add_imm,
  output logic [31:0] PC_add_4,
  input  logic        upd_valid,
  input  logic        upd_is_branch,
  input  logic [31:0] upd_PC,
  input  logic [31:0] upd_target
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits
`endif
);

  logic [IDX_W-1:0] rd_idx, up_idx;
  btb_tag_t         rd_tag, up_tag;
  btb_entry_t       rd_entry;
  logic             upd_go;

  assign rd_idx = PC_IF[IDX_W+1:2];
  assign up_idx = upd_PC[IDX_W+1:2];
  assign rd_tag = btb_tag(PC_IF, IDX_W);
  assign up_tag = btb_tag(upd_PC, IDX_W);
  assign upd_go = upd_valid && !stall;

  btb_tag_array #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (rd_idx),
    .rd_entry  (rd_entry),
    .wr_en     (upd_go && upd_is_branch),
    .wr_idx    (up_idx),
    .wr_target (upd_target),
    .wr_tag    (up_tag),
    .inv_en    (upd_go && !upd_is_branch),
    .inv_idx   (up_idx),
    .inv_tag   (up_tag)
  );

  // Hit compare and target mux; target forced to 0 on a miss.
  always_comb begin
    branch_IF  = rd_entry.valid && (rd_entry.tag == rd_tag);
    PC_add_imm = branch_IF ? rd_entry.target : 32'h0;
    PC_add_4   = PC_IF + 32'd4;
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookups_q, hits_q;

  // Saturating counters; frozen while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lookups_q <= '0;
      hits_q    <= '0;
    end else if (!stall) begin
      if (lookups_q != 32'hFFFF_FFFF) lookups_q <= lookups_q + 32'd1;
      if (branch_IF && hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_hits    = hits_q;
`else
  // Statistics build option disabled: no counters, no ports.
`endif

endmodule
